// File: rtl/cv32e40px_core_v_xif_pkg.sv
// Shared types for the X-interface offload tracker: per-entry state and stored fields,
// plus the helper that turns one entry into its pending-write register mask.
package cv32e40px_core_v_xif_pkg;

  typedef enum logic [1:0] {
    ENTRY_FREE      = 2'd0,
    ENTRY_ISSUED    = 2'd1,
    ENTRY_COMMITTED = 2'd2
  } entry_state_e;

  typedef struct packed {
    entry_state_e state;
    logic [4:0]   rd;
    logic         writeback;
    logic         dualwrite;
    logic         loadstore;
  } entry_t;

  // x0 is never a real destination, so its bit is forced clear
  function automatic logic [31:0] entry_wr_mask(entry_t e, logic dual_en);
    logic [31:0] m;
    m = '0;
    if (e.state != ENTRY_FREE) begin
      if (e.writeback) m[e.rd] = 1'b1;
      if (dual_en && e.dualwrite) m[e.rd | 5'd1] = 1'b1;
    end
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/cv32e40px_x_offload_entry.sv
// One slot of the outstanding-offload table: lifecycle state, stored offload ID
// and the destination/kind fields captured at allocation.
module cv32e40px_x_offload_entry
  import cv32e40px_core_v_xif_pkg::*;
#(
  parameter int ID_WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_i,
  input  logic [ID_WIDTH-1:0] alloc_id_i,
  input  logic [4:0]          alloc_rd_i,
  input  logic                alloc_writeback_i,
  input  logic                alloc_dualwrite_i,
  input  logic                alloc_loadstore_i,
  input  logic                commit_i,
  input  logic                kill_i,
  input  logic                free_i,
  output entry_t              entry_o,
  output logic [ID_WIDTH-1:0] id_o
);

  entry_t              entry_d, entry_q;
  logic [ID_WIDTH-1:0] id_d, id_q;

  // A result retiring the entry wins over a commit landing in the same cycle
  always_comb begin
    entry_d = entry_q;
    id_d    = id_q;
    if (alloc_i) begin
      entry_d.state     = ENTRY_ISSUED;
      entry_d.rd        = alloc_rd_i;
      entry_d.writeback = alloc_writeback_i;
      entry_d.dualwrite = alloc_dualwrite_i;
      entry_d.loadstore = alloc_loadstore_i;
      id_d              = alloc_id_i;
    end else if (free_i) begin
      entry_d.state = ENTRY_FREE;
    end else if (commit_i && entry_q.state == ENTRY_ISSUED) begin
      entry_d.state = kill_i ? ENTRY_FREE : ENTRY_COMMITTED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '0;
      id_q    <= '0;
    end else begin
      entry_q <= entry_d;
      id_q    <= id_d;
    end
  end

  assign entry_o = entry_q;
  assign id_o    = id_q;

endmodule

// File: rtl/cv32e40px_x_offload_tracker.sv
// Tracks offloaded instructions from issue to result: register scoreboard, hazard lookup,
// load/store count. CV32E40PX_XIF_COMMIT_KILL_EN makes commit+kill free an issued entry.
module cv32e40px_x_offload_tracker
  import cv32e40px_core_v_xif_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int ID_WIDTH    = 4,
  parameter int X_DUALWRITE = 0,
  localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  input  logic                 issue_ready_i,
  input  logic                 issue_accept_i,
  input  logic                 issue_writeback_i,
  input  logic                 issue_dualwrite_i,
  input  logic                 issue_loadstore_i,
  input  logic [4:0]           issue_rd_i,
  output logic [ID_WIDTH-1:0]  issue_id_o,
  output logic                 full_o,
  output logic                 empty_o,
  input  logic                 commit_valid_i,
  input  logic [ID_WIDTH-1:0]  commit_id_i,
  input  logic                 commit_kill_i,
  input  logic                 result_valid_i,
  input  logic [ID_WIDTH-1:0]  result_id_i,
  input  logic [1:0]           result_we_i,
  output logic                 result_err_o,
  input  logic                 mem_done_i,
  output logic [CNT_W-1:0]     mem_outstanding_o,
  input  logic [2:0][4:0]      rs_addr_i,
  output logic [2:0]           rs_busy_o,
  output logic [31:0]          scoreboard_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  entry_t [NUM_ENTRIES-1:0]               entries;
  logic   [NUM_ENTRIES-1:0][ID_WIDTH-1:0] entry_ids;

  logic [ID_WIDTH-1:0] issue_id_d, issue_id_q;
  logic [CNT_W-1:0]    mem_d, mem_q;
  logic                err_d, err_q;
  logic [IDX_W-1:0]    issue_slot, res_slot, cmt_slot;
  logic                alloc, res_hit, cmt_hit, kill_en, kill_ls, mem_underflow;
  logic [CNT_W:0]      mem_avail;
  logic                unused_inputs;

  // result_we_i carries writeback detail the tracker does not need
  assign unused_inputs = ^{result_we_i, commit_kill_i};

`ifdef CV32E40PX_XIF_COMMIT_KILL_EN
  assign kill_en = commit_kill_i;
`else
  assign kill_en = 1'b0;
`endif

  assign issue_slot = issue_id_q[IDX_W-1:0];
  assign res_slot   = result_id_i[IDX_W-1:0];
  assign cmt_slot   = commit_id_i[IDX_W-1:0];

  assign full_o  = entries[issue_slot].state != ENTRY_FREE;
  assign alloc   = issue_valid_i & issue_ready_i & issue_accept_i & ~full_o;
  assign res_hit = result_valid_i && entries[res_slot].state != ENTRY_FREE
                   && entry_ids[res_slot] == result_id_i;
  assign cmt_hit = commit_valid_i && entry_ids[cmt_slot] == commit_id_i;
  assign kill_ls = cmt_hit && kill_en && entries[cmt_slot].state == ENTRY_ISSUED
                   && entries[cmt_slot].loadstore;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
    cv32e40px_x_offload_entry #(.ID_WIDTH(ID_WIDTH)) u_entry (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .alloc_i           (alloc && issue_slot == IDX_W'(g)),
      .alloc_id_i        (issue_id_q),
      .alloc_rd_i        (issue_rd_i),
      .alloc_writeback_i (issue_writeback_i),
      .alloc_dualwrite_i (issue_dualwrite_i),
      .alloc_loadstore_i (issue_loadstore_i),
      .commit_i          (cmt_hit && cmt_slot == IDX_W'(g)),
      .kill_i            (kill_en),
      .free_i            (res_hit && res_slot == IDX_W'(g)),
      .entry_o           (entries[g]),
      .id_o              (entry_ids[g])
    );
  end

  // mem_done_i with nothing left to retire is dropped and reported as an error
  always_comb begin
    mem_avail     = {1'b0, mem_q} + {{CNT_W{1'b0}}, alloc & issue_loadstore_i}
                    - {{CNT_W{1'b0}}, kill_ls};
    mem_underflow = mem_done_i && (mem_avail == '0);
    mem_d         = mem_avail[CNT_W-1:0]
                    - {{(CNT_W-1){1'b0}}, mem_done_i & ~mem_underflow};
    issue_id_d    = issue_id_q + {{(ID_WIDTH-1){1'b0}}, alloc};
    err_d         = (result_valid_i & ~res_hit) | mem_underflow;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_id_q <= '0;
      mem_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      issue_id_q <= issue_id_d;
      mem_q      <= mem_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    scoreboard_o = '0;
    empty_o      = 1'b1;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      scoreboard_o = scoreboard_o | entry_wr_mask(entries[i], X_DUALWRITE != 0);
      if (entries[i].state != ENTRY_FREE) empty_o = 1'b0;
    end
  end

  always_comb begin
    rs_busy_o = '0;
    for (int i = 0; i < 3; i++) rs_busy_o[i] = scoreboard_o[rs_addr_i[i]];
  end

  assign issue_id_o        = issue_id_q;
  assign mem_outstanding_o = mem_q;
  assign result_err_o      = err_q;

endmodule

// File: tb/tb_cv32e40px_x_offload_tracker.sv
// Self-checking bench for cv32e40px_x_offload_tracker (4 entries, dual write enabled);
// expectations adapt to whether CV32E40PX_XIF_COMMIT_KILL_EN is defined.
module tb_cv32e40px_x_offload_tracker;

`ifdef CV32E40PX_XIF_COMMIT_KILL_EN
  localparam bit KILL_EN = 1'b1;
`else
  localparam bit KILL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            issue_valid = 0, issue_ready = 0, issue_accept = 0;
  logic            issue_wb = 0, issue_dw = 0, issue_ls = 0;
  logic [4:0]      issue_rd = '0;
  logic [3:0]      issue_id;
  logic            full, empty, result_err;
  logic            commit_valid = 0, commit_kill = 0;
  logic [3:0]      commit_id = '0;
  logic            result_valid = 0;
  logic [3:0]      result_id = '0;
  logic [1:0]      result_we = '0;
  logic            mem_done = 0;
  logic [2:0]      mem_out;
  logic [2:0][4:0] rs_addr = {5'd9, 5'd7, 5'd5};
  logic [2:0]      rs_busy;
  logic [31:0]     scoreboard;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cv32e40px_x_offload_tracker #(.NUM_ENTRIES(4), .ID_WIDTH(4), .X_DUALWRITE(1)) dut (
    .clk_i (clk), .rst_i (rst),
    .issue_valid_i (issue_valid), .issue_ready_i (issue_ready), .issue_accept_i (issue_accept),
    .issue_writeback_i (issue_wb), .issue_dualwrite_i (issue_dw), .issue_loadstore_i (issue_ls),
    .issue_rd_i (issue_rd), .issue_id_o (issue_id), .full_o (full), .empty_o (empty),
    .commit_valid_i (commit_valid), .commit_id_i (commit_id), .commit_kill_i (commit_kill),
    .result_valid_i (result_valid), .result_id_i (result_id), .result_we_i (result_we),
    .result_err_o (result_err), .mem_done_i (mem_done), .mem_outstanding_o (mem_out),
    .rs_addr_i (rs_addr), .rs_busy_o (rs_busy), .scoreboard_o (scoreboard)
  );

  typedef struct {
    logic        rst, iss, acc, wb, dw, ls, cv, ck, rv, md;
    logic [4:0]  rd;
    logic [3:0]  cid, rid;
    logic [3:0]  e_id;
    logic        e_full, e_empty, e_err;
    logic [2:0]  e_mem;
    logic [31:0] e_sb;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t idle();
    vec_t t;
    t.rst = 0; t.iss = 0; t.acc = 0; t.wb = 0; t.dw = 0; t.ls = 0;
    t.cv = 0; t.ck = 0; t.rv = 0; t.md = 0; t.rd = '0; t.cid = '0; t.rid = '0;
    t.e_id = '0; t.e_full = 0; t.e_empty = 0; t.e_err = 0; t.e_mem = '0; t.e_sb = '0;
    return t;
  endfunction

  function automatic vec_t iss(input int rd, input int wb, input int dw, input int ls, input int acc);
    vec_t t = idle();
    t.iss = 1; t.rd = 5'(rd); t.wb = 1'(wb); t.dw = 1'(dw); t.ls = 1'(ls); t.acc = 1'(acc);
    return t;
  endfunction

  function automatic vec_t res(input int id);
    vec_t t = idle();
    t.rv = 1; t.rid = 4'(id);
    return t;
  endfunction

  function automatic vec_t cmt(input int id, input int kill);
    vec_t t = idle();
    t.cv = 1; t.cid = 4'(id); t.ck = 1'(kill);
    return t;
  endfunction

  function automatic vec_t md();
    vec_t t = idle();
    t.md = 1;
    return t;
  endfunction

  function automatic vec_t ex(input vec_t t, input int id, input int fl, input int em,
                              input int er, input int mem, input logic [31:0] sb);
    vec_t r = t;
    r.e_id = 4'(id); r.e_full = 1'(fl); r.e_empty = 1'(em); r.e_err = 1'(er);
    r.e_mem = 3'(mem); r.e_sb = sb;
    return r;
  endfunction

  task automatic drive(input vec_t t);
    rst = t.rst;
    issue_valid = t.iss; issue_ready = t.iss; issue_accept = t.acc;
    issue_rd = t.rd; issue_wb = t.wb; issue_dw = t.dw; issue_ls = t.ls;
    commit_valid = t.cv; commit_id = t.cid; commit_kill = t.ck;
    result_valid = t.rv; result_id = t.rid; result_we = {t.rv, 1'b0};
    mem_done = t.md;
  endtask

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
    end
  endtask

  task automatic check_out(input vec_t e, input int step);
    chk("issue_id", step, 32'(issue_id), 32'(e.e_id));
    chk("full", step, 32'(full), 32'(e.e_full));
    chk("empty", step, 32'(empty), 32'(e.e_empty));
    chk("result_err", step, 32'(result_err), 32'(e.e_err));
    chk("mem_outstanding", step, 32'(mem_out), 32'(e.e_mem));
    chk("scoreboard", step, scoreboard, e.e_sb);
    chk("rs_busy", step, 32'(rs_busy), 32'({e.e_sb[9], e.e_sb[7], e.e_sb[5]}));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t;
    bit found;

    t = idle(); t.rst = 1;
    tbl.push_back(ex(t, 0, 0, 1, 0, 0, 32'h0));
    // single writeback issue, then its result retires it
    tbl.push_back(ex(iss(5, 1, 0, 0, 1), 1, 0, 0, 0, 0, 32'h20));
    tbl.push_back(ex(idle(),             1, 0, 0, 0, 0, 32'h20));
    tbl.push_back(ex(res(0),             1, 0, 1, 0, 0, 32'h0));
    tbl.push_back(ex(iss(9, 1, 0, 0, 0), 1, 0, 1, 0, 0, 32'h0));
    tbl.push_back(ex(res(3),             1, 0, 1, 1, 0, 32'h0));
    tbl.push_back(ex(idle(),             1, 0, 1, 0, 0, 32'h0));
    // pair writes, dualwrite without writeback, and x0
    tbl.push_back(ex(iss(6, 1, 1, 0, 1), 2, 0, 0, 0, 0, 32'hC0));
    tbl.push_back(ex(res(1),             2, 0, 1, 0, 0, 32'h0));
    tbl.push_back(ex(iss(10, 0, 1, 0, 1), 3, 0, 0, 0, 0, 32'h800));
    tbl.push_back(ex(res(2),             3, 0, 1, 0, 0, 32'h0));
    tbl.push_back(ex(iss(0, 1, 0, 0, 1), 4, 0, 0, 0, 0, 32'h0));
    tbl.push_back(ex(res(3),             4, 0, 1, 0, 0, 32'h0));
    // fill all four slots
    tbl.push_back(ex(iss(1, 1, 0, 1, 1), 5, 0, 0, 0, 1, 32'h2));
    tbl.push_back(ex(iss(2, 1, 0, 0, 1), 6, 0, 0, 0, 1, 32'h6));
    tbl.push_back(ex(iss(3, 1, 0, 0, 1), 7, 0, 0, 0, 1, 32'hE));
    tbl.push_back(ex(iss(4, 1, 0, 0, 1), 8, 1, 0, 0, 1, 32'h1E));
    tbl.push_back(ex(iss(9, 1, 0, 1, 1), 8, 1, 0, 0, 1, 32'h1E));
    tbl.push_back(ex(res(0),             8, 1, 0, 1, 1, 32'h1E));
    tbl.push_back(ex(res(4),             8, 0, 0, 0, 1, 32'h1C));
    t = iss(9, 1, 0, 0, 1); t.rv = 1; t.rid = 4'd5;
    tbl.push_back(ex(t,                  9, 0, 0, 0, 1, 32'h218));
    // load/store counting and underflow
    tbl.push_back(ex(md(),               9, 0, 0, 0, 0, 32'h218));
    tbl.push_back(ex(md(),               9, 0, 0, 1, 0, 32'h218));
    tbl.push_back(ex(idle(),             9, 0, 0, 0, 0, 32'h218));
    tbl.push_back(ex(iss(12, 0, 0, 1, 1), 10, 1, 0, 0, 1, 32'h218));
    tbl.push_back(ex(res(6),             10, 0, 0, 0, 1, 32'h210));
    t = iss(13, 0, 0, 1, 1); t.md = 1;
    tbl.push_back(ex(t,                  11, 1, 0, 0, 1, 32'h210));
    // commit with kill on an issued load/store
    tbl.push_back(ex(cmt(9, 1),          11, 1, 0, 0, KILL_EN ? 0 : 1, 32'h210));
    tbl.push_back(ex(res(9),             11, 1, 0, KILL_EN ? 1 : 0, KILL_EN ? 0 : 1, 32'h210));
    tbl.push_back(ex(cmt(10, 0),         11, 1, 0, 0, KILL_EN ? 0 : 1, 32'h210));
    tbl.push_back(ex(cmt(10, 1),         11, 1, 0, 0, KILL_EN ? 0 : 1, 32'h210));
    tbl.push_back(ex(res(10),            11, 1, 0, 0, KILL_EN ? 0 : 1, 32'h210));
    tbl.push_back(ex(res(7),             11, 0, 0, 0, KILL_EN ? 0 : 1, 32'h200));
    tbl.push_back(ex(res(8),             11, 0, 1, 0, KILL_EN ? 0 : 1, 32'h0));
    tbl.push_back(ex(iss(5, 1, 0, 1, 1), 12, 0, 0, 0, KILL_EN ? 1 : 2, 32'h20));
    // reset mid-operation alongside a result that would otherwise be an error
    t = res(0); t.rst = 1;
    tbl.push_back(ex(t,                  0, 0, 1, 0, 0, 32'h0));
    tbl.push_back(ex(idle(),             0, 0, 1, 0, 0, 32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      check_out(exp_q.pop_front(), i);
    end

    // rs_busy follows rs_addr with no clock edge in between
    @(negedge clk);
    drive(iss(20, 1, 0, 0, 1));
    @(negedge clk);
    drive(idle());
    rs_addr[2] = 5'd20;
    #1;
    chk("rs_busy_comb_hit", 100, 32'(rs_busy[2]), 32'd1);
    rs_addr[2] = 5'd21;
    #1;
    chk("rs_busy_comb_miss", 101, 32'(rs_busy[2]), 32'd0);
    rs_addr[2] = 5'd9;

    // retire it and wait, bounded, for the table to drain
    @(negedge clk);
    drive(res(0));
    found = 0;
    for (int c = 0; c < 5 && !found; c++) begin
      @(posedge clk);
      #1;
      if (empty) found = 1;
      @(negedge clk);
      drive(idle());
    end
    chk("drain_empty", 102, 32'(found), 32'd1);
    chk("drain_scoreboard", 103, scoreboard, 32'h0);
    chk("drain_err", 104, 32'(result_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
